// File: rtl/nrisc_mux_pkg.sv
// Shared constants and types for the NRISC 16-lane collector and its arbiter.
package nrisc_mux_pkg;

    localparam int NSRC    = 16;
    localparam int SELW    = 4;
    localparam int DEF_TAM = 16;

    typedef logic [SELW-1:0] lane_idx_t;

    // Successor lane; the 4-bit type gives the 15 -> 0 wrap for free.
    function automatic lane_idx_t next_lane(input lane_idx_t idx);
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/nrisc_rr_arb16.sv
// Combinational 16-way round-robin arbiter: first requester at or above ptr, wrapping.
module nrisc_rr_arb16
    import nrisc_mux_pkg::*;
(
    input  logic [NSRC-1:0] req,
    input  lane_idx_t       ptr,
    output logic [NSRC-1:0] grant,
    output lane_idx_t       grant_idx,
    output logic            grant_exists
);

    lane_idx_t cand_s;

    // Rotating priority search starting at ptr.
    always_comb begin
        cand_s       = ptr;
        grant_idx    = ptr;
        grant_exists = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            cand_s = ptr + lane_idx_t'(k);
            if (!grant_exists && req[cand_s]) begin
                grant_exists = 1'b1;
                grant_idx    = cand_s;
            end else begin
                grant_exists = grant_exists;
            end
        end
    end

    // One-hot form of the winning index.
    always_comb begin
        grant = {NSRC{1'b0}};
        if (grant_exists) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = {NSRC{1'b0}};
        end
    end

endmodule

// File: rtl/nrisc_mux16_arb.sv
// Merges 16 valid/ready producer lanes onto one registered output lane,
// with round-robin or forced lane selection.
module nrisc_mux16_arb
    import nrisc_mux_pkg::*;
#(
    parameter int TAM = DEF_TAM
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NSRC*TAM-1:0] mux_in,
    input  logic [NSRC-1:0]     mux_valid,
    output logic [NSRC-1:0]     mux_ready,
    input  logic                mux_force_en,
    input  logic [SELW-1:0]     mux_force_sel,
    output logic [TAM-1:0]      out_data,
    output logic [SELW-1:0]     out_sel,
    output logic                out_valid,
    input  logic                out_ready
);

    logic [NSRC-1:0] req_s;
    logic [NSRC-1:0] grant_s;
    lane_idx_t       grant_idx_s;
    logic            grant_exists_s;
    logic            load_en_s;
    logic            take_s;
    logic [TAM-1:0]  lane_data_s;

    lane_idx_t       ptr_r;
    lane_idx_t       out_sel_r;
    logic [TAM-1:0]  out_data_r;
    logic            out_valid_r;

    // Forcing masks the request down to the selected lane, so the arbiter
    // can only pick that lane regardless of ptr.
    always_comb begin
        req_s = {NSRC{1'b0}};
        if (mux_force_en) begin
            req_s = mux_valid & ({{(NSRC-1){1'b0}}, 1'b1} << mux_force_sel);
        end else begin
            req_s = mux_valid;
        end
    end

    nrisc_rr_arb16 u_arb (
        .req          (req_s),
        .ptr          (ptr_r),
        .grant        (grant_s),
        .grant_idx    (grant_idx_s),
        .grant_exists (grant_exists_s)
    );

    // Load enable, transfer qualification and the granted lane's data.
    always_comb begin
        load_en_s   = ~out_valid_r | out_ready;
        take_s      = load_en_s & grant_exists_s;
        lane_data_s = mux_in[grant_idx_s*TAM +: TAM];
    end

    // Ready is forced low while reset is asserted, even though the output
    // register is empty and would otherwise accept.
    always_comb begin
        mux_ready = {NSRC{1'b0}};
        if (rst_n) begin
            mux_ready = grant_s & {NSRC{take_s}};
        end else begin
            mux_ready = {NSRC{1'b0}};
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {TAM{1'b0}};
            out_sel_r   <= 4'd0;
            ptr_r       <= 4'd0;
        end else if (take_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= lane_data_s;
            out_sel_r   <= grant_idx_s;
            ptr_r       <= next_lane(grant_idx_s);
        end else if (load_en_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign out_valid = out_valid_r;

endmodule
